// File: rtl/ex_stage_if.sv
// ID/EX inputs, forwarding selects and EX/MEM, HI/LO and freeze outputs of the execute stage.
interface ex_stage_if #(
  parameter int unsigned WIDTH = 32
);
  logic             IdExValid;
  logic [WIDTH-1:0] IdExRsData;
  logic [WIDTH-1:0] IdExRtData;
  logic [WIDTH-1:0] IdExImm;
  logic [4:0]       IdExShamt;
  logic [4:0]       IdExAluOp;
  logic             IdExAluSrc;
  logic             IdExRegDst;
  logic [4:0]       IdExRt;
  logic [4:0]       IdExRd;
  logic             IdExRegWrite;
  logic             IdExMemRead;
  logic             IdExMemWrite;
  logic             IdExMemToReg;
  logic [1:0]       FwdA;
  logic [1:0]       FwdB;
  logic [WIDTH-1:0] MemWbData;

  logic [WIDTH-1:0] ExMemAluOut;
  logic [WIDTH-1:0] ExMemStoreData;
  logic [4:0]       ExMemRd;
  logic             ExMemWb;
  logic             ExMemMemRead;
  logic             ExMemMemWrite;
  logic             ExMemMemToReg;
  logic             ExBusy;
  logic [WIDTH-1:0] Hi;
  logic [WIDTH-1:0] Lo;

  modport master (
    output IdExValid, IdExRsData, IdExRtData, IdExImm, IdExShamt, IdExAluOp,
           IdExAluSrc, IdExRegDst, IdExRt, IdExRd, IdExRegWrite, IdExMemRead,
           IdExMemWrite, IdExMemToReg, FwdA, FwdB, MemWbData,
    input  ExMemAluOut, ExMemStoreData, ExMemRd, ExMemWb, ExMemMemRead,
           ExMemMemWrite, ExMemMemToReg, ExBusy, Hi, Lo
  );

  modport slave (
    input  IdExValid, IdExRsData, IdExRtData, IdExImm, IdExShamt, IdExAluOp,
           IdExAluSrc, IdExRegDst, IdExRt, IdExRd, IdExRegWrite, IdExMemRead,
           IdExMemWrite, IdExMemToReg, FwdA, FwdB, MemWbData,
    output ExMemAluOut, ExMemStoreData, ExMemRd, ExMemWb, ExMemMemRead,
           ExMemMemWrite, ExMemMemToReg, ExBusy, Hi, Lo
  );
endinterface

// File: rtl/ex_stage.sv
// MIPS execute stage: forwarding muxes, single-cycle ALU, EX/MEM register and an
// iterative multiply/divide unit whose busy state freezes the pipeline.
module ex_stage #(
  parameter int unsigned WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  ex_stage_if.slave   bus
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [4:0] OP_ADD  = 5'h00;
  localparam logic [4:0] OP_SUB  = 5'h01;
  localparam logic [4:0] OP_AND  = 5'h02;
  localparam logic [4:0] OP_OR   = 5'h03;
  localparam logic [4:0] OP_XOR  = 5'h04;
  localparam logic [4:0] OP_NOR  = 5'h05;
  localparam logic [4:0] OP_SLT  = 5'h06;
  localparam logic [4:0] OP_SLTU = 5'h07;
  localparam logic [4:0] OP_SLL  = 5'h08;
  localparam logic [4:0] OP_SRL  = 5'h09;
  localparam logic [4:0] OP_SRA  = 5'h0A;
  localparam logic [4:0] OP_LUI  = 5'h0B;
  localparam logic [4:0] OP_MFHI = 5'h10;
  localparam logic [4:0] OP_MFLO = 5'h11;

  typedef enum logic [0:0] {IDLE, BUSY} md_state_e;

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] wrk_q, wrk_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             is_div_q, is_div_d;
  logic             neg_q, neg_d;
  logic             rneg_q, rneg_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic [WIDTH-1:0] alu_q, store_q;
  logic [4:0]       rd_q;
  logic             wb_q, mr_q, mw_q, m2r_q;

  logic [WIDTH-1:0] op_a, rt_val, op_b, alu_res;
  logic [4:0]       dst;
  logic             is_md, md_signed, sa, sb;
  logic [WIDTH-1:0] mag_a, mag_b;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_acc, mul_wrk;
  logic [WIDTH:0]   div_sh;
  logic [WIDTH+1:0] div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] div_acc, div_wrk;
  logic [2*WIDTH-1:0] prod;
  logic             last_step;

  // Operand selection from register file, MEM/WB or EX/MEM
  always_comb begin
    op_a   = bus.IdExRsData;
    rt_val = bus.IdExRtData;
    case (bus.FwdA)
      2'd1:    op_a = bus.MemWbData;
      2'd2:    op_a = alu_q;
      default: op_a = bus.IdExRsData;
    endcase
    case (bus.FwdB)
      2'd1:    rt_val = bus.MemWbData;
      2'd2:    rt_val = alu_q;
      default: rt_val = bus.IdExRtData;
    endcase
    op_b = bus.IdExAluSrc ? bus.IdExImm : rt_val;
    dst  = bus.IdExRegDst ? bus.IdExRd : bus.IdExRt;
  end

  always_comb begin
    alu_res = '0;
    case (bus.IdExAluOp)
      OP_ADD:  alu_res = op_a + op_b;
      OP_SUB:  alu_res = op_a - op_b;
      OP_AND:  alu_res = op_a & op_b;
      OP_OR:   alu_res = op_a | op_b;
      OP_XOR:  alu_res = op_a ^ op_b;
      OP_NOR:  alu_res = ~(op_a | op_b);
      OP_SLT:  alu_res = WIDTH'($signed(op_a) < $signed(op_b));
      OP_SLTU: alu_res = WIDTH'(op_a < op_b);
      OP_SLL:  alu_res = op_b << bus.IdExShamt;
      OP_SRL:  alu_res = op_b >> bus.IdExShamt;
      OP_SRA:  alu_res = WIDTH'($signed(op_b) >>> bus.IdExShamt);
      OP_LUI:  alu_res = WIDTH'({op_b[15:0], 16'h0000});
      OP_MFHI: alu_res = hi_q;
      OP_MFLO: alu_res = lo_q;
      default: alu_res = '0;
    endcase
  end

  assign is_md     = (bus.IdExAluOp[4:2] == 3'b011);
  assign md_signed = ~bus.IdExAluOp[0];
  assign sa        = md_signed & op_a[WIDTH-1];
  assign sb        = md_signed & op_b[WIDTH-1];
  assign mag_a     = sa ? (-op_a) : op_a;
  assign mag_b     = sb ? (-op_b) : op_b;

  // EX/MEM register; frozen while the multiply/divide unit is busy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_q   <= '0;
      store_q <= '0;
      rd_q    <= '0;
      wb_q    <= 1'b0;
      mr_q    <= 1'b0;
      mw_q    <= 1'b0;
      m2r_q   <= 1'b0;
    end else if (state_q == IDLE) begin
      alu_q   <= alu_res;
      store_q <= rt_val;
      rd_q    <= dst;
      wb_q    <= bus.IdExValid & bus.IdExRegWrite & ~is_md;
      mr_q    <= bus.IdExValid & bus.IdExMemRead & ~is_md;
      mw_q    <= bus.IdExValid & bus.IdExMemWrite & ~is_md;
      m2r_q   <= bus.IdExMemToReg;
    end
  end

  // One shift-add (multiply) or restoring-subtract (divide) step on the working registers
  always_comb begin
    mul_sum  = {1'b0, acc_q} + (wrk_q[0] ? {1'b0, dvs_q} : '0);
    mul_acc  = mul_sum[WIDTH:1];
    mul_wrk  = {mul_sum[0], wrk_q[WIDTH-1:1]};
    div_sh   = {acc_q, wrk_q[WIDTH-1]};
    div_diff = {1'b0, div_sh} - {2'b00, dvs_q};
    div_ge   = ~div_diff[WIDTH+1];
    div_acc  = div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
    div_wrk  = {wrk_q[WIDTH-2:0], div_ge};
    prod     = {mul_acc, mul_wrk};
  end

  assign last_step = (cnt_q == CNT_W'(WIDTH - 1));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    wrk_d    = wrk_q;
    dvs_d    = dvs_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state_q)
      IDLE: begin
        if (bus.IdExValid && is_md) begin
          state_d  = BUSY;
          cnt_d    = '0;
          acc_d    = '0;
          wrk_d    = mag_a;
          dvs_d    = mag_b;
          is_div_d = bus.IdExAluOp[1];
          // Divide by zero keeps an all-ones quotient regardless of dividend sign
          neg_d    = (sa ^ sb) & ~(bus.IdExAluOp[1] & (mag_b == '0));
          rneg_d   = sa;
        end
      end
      BUSY: begin
        cnt_d = cnt_q + CNT_W'(1);
        acc_d = is_div_q ? div_acc : mul_acc;
        wrk_d = is_div_q ? div_wrk : mul_wrk;
        if (last_step) begin
          state_d = IDLE;
          cnt_d   = '0;
          if (is_div_q) begin
            lo_d = neg_q  ? (-div_wrk) : div_wrk;
            hi_d = rneg_q ? (-div_acc) : div_acc;
          end else begin
            {hi_d, lo_d} = neg_q ? (-prod) : prod;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      wrk_q    <= '0;
      dvs_q    <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      wrk_q    <= wrk_d;
      dvs_q    <= dvs_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign bus.ExMemAluOut    = alu_q;
  assign bus.ExMemStoreData = store_q;
  assign bus.ExMemRd        = rd_q;
  assign bus.ExMemWb        = wb_q;
  assign bus.ExMemMemRead   = mr_q;
  assign bus.ExMemMemWrite  = mw_q;
  assign bus.ExMemMemToReg  = m2r_q;
  assign bus.ExBusy         = (state_q == BUSY);
  assign bus.Hi             = hi_q;
  assign bus.Lo             = lo_q;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: forwarding, ALU ops, bubbles, multiply/divide and reset abort.
module tb_ex_stage;

  localparam logic [4:0] ADD = 5'h00, SUB = 5'h01, NOR = 5'h05, SLT = 5'h06, SLTU = 5'h07;
  localparam logic [4:0] SRA = 5'h0A, LUI = 5'h0B, MULT = 5'h0C, MULTU = 5'h0D;
  localparam logic [4:0] DIV = 5'h0E, DIVU = 5'h0F, MFHI = 5'h10, MFLO = 5'h11;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;
  int   n;

  ex_stage_if #(.WIDTH(32)) bus ();

  ex_stage #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [4:0] op, input logic [31:0] rs, input logic [31:0] rt,
                       input logic [31:0] imm, input logic src, input logic [4:0] rd,
                       input logic rw, input logic mw, input logic [1:0] fa, input logic [1:0] fb);
    bus.IdExValid    = 1'b1;
    bus.IdExAluOp    = op;
    bus.IdExRsData   = rs;
    bus.IdExRtData   = rt;
    bus.IdExImm      = imm;
    bus.IdExAluSrc   = src;
    bus.IdExRegDst   = 1'b1;
    bus.IdExRt       = 5'd2;
    bus.IdExRd       = rd;
    bus.IdExRegWrite = rw;
    bus.IdExMemRead  = 1'b0;
    bus.IdExMemWrite = mw;
    bus.IdExMemToReg = 1'b0;
    bus.IdExShamt    = 5'd0;
    bus.FwdA         = fa;
    bus.FwdB         = fb;
  endtask

  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (bus.ExBusy === 1'b1 && cycles < 200) begin
      tick();
      cycles++;
    end
  endtask

  initial begin
    issue(ADD, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 2'd0, 2'd0);
    bus.IdExValid = 1'b0;
    bus.MemWbData = 32'd7;
    repeat (2) tick();
    chk("rst_aluout", 64'(bus.ExMemAluOut), 64'h0);
    chk("rst_wb", 64'(bus.ExMemWb), 64'h0);
    chk("rst_busy", 64'(bus.ExBusy), 64'h0);
    chk("rst_hi", 64'(bus.Hi), 64'h0);
    chk("rst_lo", 64'(bus.Lo), 64'h0);
    rst_n = 1'b1;

    issue(ADD, 32'd5, 32'd0, 32'd0, 1'b1, 5'd3, 1'b1, 1'b0, 2'd0, 2'd0);
    tick();
    chk("seed_aluout", 64'(bus.ExMemAluOut), 64'd5);

    issue(ADD, 32'hDEAD, 32'hBEEF, 32'd0, 1'b0, 5'd9, 1'b1, 1'b0, 2'd2, 2'd1);
    tick();
    chk("add_fwd", 64'(bus.ExMemAluOut), 64'd12);
    chk("add_wb", 64'(bus.ExMemWb), 64'd1);
    chk("add_rd", 64'(bus.ExMemRd), 64'd9);

    issue(ADD, 32'h100, 32'hBEEF, 32'd4, 1'b1, 5'd0, 1'b0, 1'b1, 2'd0, 2'd2);
    tick();
    chk("sw_addr", 64'(bus.ExMemAluOut), 64'h104);
    chk("sw_data", 64'(bus.ExMemStoreData), 64'd12);
    chk("sw_memwrite", 64'(bus.ExMemMemWrite), 64'd1);
    chk("sw_wb", 64'(bus.ExMemWb), 64'd0);

    issue(SUB, 32'd3, 32'd5, 32'd0, 1'b0, 5'd1, 1'b1, 1'b0, 2'd0, 2'd0);
    tick();
    chk("sub", 64'(bus.ExMemAluOut), 64'hFFFFFFFE);

    issue(SLT, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 5'd1, 1'b1, 1'b0, 2'd3, 2'd3);
    tick();
    chk("slt", 64'(bus.ExMemAluOut), 64'd1);

    issue(SLTU, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 5'd1, 1'b1, 1'b0, 2'd0, 2'd0);
    tick();
    chk("sltu", 64'(bus.ExMemAluOut), 64'd0);

    issue(SRA, 32'd0, 32'h80000000, 32'd0, 1'b0, 5'd1, 1'b1, 1'b0, 2'd0, 2'd0);
    bus.IdExShamt = 5'd4;
    tick();
    chk("sra", 64'(bus.ExMemAluOut), 64'hF8000000);

    issue(LUI, 32'd0, 32'd0, 32'h00001234, 1'b1, 5'd1, 1'b1, 1'b0, 2'd0, 2'd0);
    tick();
    chk("lui", 64'(bus.ExMemAluOut), 64'h12340000);

    issue(NOR, 32'h0F0F0000, 32'h00F0F0F0, 32'd0, 1'b0, 5'd1, 1'b1, 1'b0, 2'd0, 2'd0);
    tick();
    chk("nor", 64'(bus.ExMemAluOut), 64'hF0000F0F);

    issue(5'h1F, 32'd1, 32'd2, 32'd0, 1'b0, 5'd1, 1'b1, 1'b0, 2'd0, 2'd0);
    tick();
    chk("undef_op", 64'(bus.ExMemAluOut), 64'd0);

    issue(ADD, 32'd1, 32'd1, 32'd0, 1'b0, 5'd1, 1'b1, 1'b1, 2'd0, 2'd0);
    bus.IdExValid = 1'b0;
    tick();
    chk("bubble_wb", 64'(bus.ExMemWb), 64'd0);
    chk("bubble_mw", 64'(bus.ExMemMemWrite), 64'd0);

    // MULT followed directly by MFLO, which must see the final LO
    issue(MULT, 32'hFFFFFFFE, 32'd3, 32'd0, 1'b0, 5'd1, 1'b1, 1'b0, 2'd0, 2'd0);
    tick();
    chk("mult_busy_rise", 64'(bus.ExBusy), 64'd1);
    chk("mult_wb", 64'(bus.ExMemWb), 64'd0);
    issue(MFLO, 32'd0, 32'd0, 32'd0, 1'b0, 5'd4, 1'b1, 1'b0, 2'd0, 2'd0);
    wait_idle(n);
    chk("mult_busy_cycles", 64'(n), 64'd32);
    chk("mult_exmem_held", 64'(bus.ExMemWb), 64'd0);
    chk("mult_hi", 64'(bus.Hi), 64'hFFFFFFFF);
    chk("mult_lo", 64'(bus.Lo), 64'hFFFFFFFA);
    tick();
    chk("mflo_val", 64'(bus.ExMemAluOut), 64'hFFFFFFFA);
    chk("mflo_wb", 64'(bus.ExMemWb), 64'd1);
    chk("mflo_rd", 64'(bus.ExMemRd), 64'd4);

    issue(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 1'b0, 5'd1, 1'b0, 1'b0, 2'd0, 2'd0);
    tick();
    bus.IdExValid = 1'b0;
    wait_idle(n);
    chk("multu_hi", 64'(bus.Hi), 64'hFFFFFFFE);
    chk("multu_lo", 64'(bus.Lo), 64'h00000001);

    issue(DIV, 32'hFFFFFFF9, 32'd2, 32'd0, 1'b0, 5'd1, 1'b0, 1'b0, 2'd0, 2'd0);
    tick();
    bus.IdExValid = 1'b0;
    wait_idle(n);
    chk("div_lo", 64'(bus.Lo), 64'hFFFFFFFD);
    chk("div_hi", 64'(bus.Hi), 64'hFFFFFFFF);

    issue(DIV, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1'b0, 5'd1, 1'b0, 1'b0, 2'd0, 2'd0);
    tick();
    bus.IdExValid = 1'b0;
    wait_idle(n);
    chk("div_ovf_lo", 64'(bus.Lo), 64'h80000000);
    chk("div_ovf_hi", 64'(bus.Hi), 64'h0);

    issue(DIV, 32'hFFFFFFF7, 32'd0, 32'd0, 1'b0, 5'd1, 1'b0, 1'b0, 2'd0, 2'd0);
    tick();
    bus.IdExValid = 1'b0;
    wait_idle(n);
    chk("div0s_lo", 64'(bus.Lo), 64'hFFFFFFFF);
    chk("div0s_hi", 64'(bus.Hi), 64'hFFFFFFF7);

    issue(DIVU, 32'd9, 32'd0, 32'd0, 1'b0, 5'd1, 1'b0, 1'b0, 2'd0, 2'd0);
    tick();
    bus.IdExValid = 1'b0;
    wait_idle(n);
    chk("divu0_lo", 64'(bus.Lo), 64'hFFFFFFFF);
    chk("divu0_hi", 64'(bus.Hi), 64'd9);

    issue(MFHI, 32'd0, 32'd0, 32'd0, 1'b0, 5'd5, 1'b1, 1'b0, 2'd0, 2'd0);
    tick();
    chk("mfhi_val", 64'(bus.ExMemAluOut), 64'd9);

    // Reset during busy cycle 10 of a DIVU
    issue(DIVU, 32'd100, 32'd7, 32'd0, 1'b0, 5'd1, 1'b0, 1'b0, 2'd0, 2'd0);
    tick();
    bus.IdExValid = 1'b0;
    repeat (9) tick();
    chk("abort_busy_before", 64'(bus.ExBusy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 64'(bus.ExBusy), 64'd0);
    chk("abort_hi", 64'(bus.Hi), 64'd0);
    chk("abort_lo", 64'(bus.Lo), 64'd0);
    chk("abort_aluout", 64'(bus.ExMemAluOut), 64'd0);
    #2;
    rst_n = 1'b1;
    issue(ADD, 32'd2, 32'd3, 32'd0, 1'b0, 5'd6, 1'b1, 1'b0, 2'd0, 2'd0);
    tick();
    chk("post_abort_add", 64'(bus.ExMemAluOut), 64'd5);
    chk("post_abort_busy", 64'(bus.ExBusy), 64'd0);
    chk("post_abort_wb", 64'(bus.ExMemWb), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage MIPS pipeline, directly downstream of the forwarding unit.
- Consumes FwdA/FwdB to select ALU operands from ID/EX, EX/MEM or MEM/WB data, then executes the ALU op.
- Owns the EX/MEM pipeline register, whose outputs feed back to the forwarding unit and to the MEM stage.
- Contains an iterative multiply/divide unit with HI/LO registers; while it runs, ExBusy freezes the whole pipeline.

Parameters:
- WIDTH, 32, datapath width; multiply/divide takes WIDTH busy cycles.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- IdExValid  in  1  ID/EX holds a real instruction (0 = bubble).
- IdExRsData  in  WIDTH  register-file rs value.
- IdExRtData  in  WIDTH  register-file rt value.
- IdExImm  in  WIDTH  sign/zero-extended immediate.
- IdExShamt  in  5  shift amount.
- IdExAluOp  in  5  operation code, listed under Behaviour.
- IdExAluSrc  in  1  1 = operand B is IdExImm.
- IdExRegDst  in  1  1 = destination is Rd, 0 = Rt.
- IdExRt  in  5  rt index.
- IdExRd  in  5  rd index.
- IdExRegWrite  in  1  write-back enable.
- IdExMemRead  in  1  load.
- IdExMemWrite  in  1  store.
- IdExMemToReg  in  1  write-back source select.
- FwdA  in  2  forwarding select for rs.
- FwdB  in  2  forwarding select for rt.
- MemWbData  in  WIDTH  MEM/WB write-back value.
- ExMemAluOut  out  WIDTH  registered ALU result.
- ExMemStoreData  out  WIDTH  registered forwarded rt value.
- ExMemRd  out  5  registered destination index.
- ExMemWb  out  1  registered RegWrite.
- ExMemMemRead  out  1  registered MemRead.
- ExMemMemWrite  out  1  registered MemWrite.
- ExMemMemToReg  out  1  registered MemToReg.
- ExBusy  out  1  multiply/divide running; global freeze of PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Hi  out  WIDTH  HI register.
- Lo  out  WIDTH  LO register.

Behaviour:
- Reset: all EX/MEM outputs, Hi, Lo and ExBusy are 0; state is IDLE; the iteration counter is 0. Reset asserted mid multiply/divide aborts it immediately.
- Operand A by FwdA: 0 selects IdExRsData, 1 selects MemWbData, 2 selects ExMemAluOut, 3 behaves as 0.
- Rt value by FwdB uses the same mapping on IdExRtData.
- Operand B = IdExAluSrc ? IdExImm : rt value. ExMemStoreData always takes the rt value.
- AluOp codes and results:
  - 00 ADD, 01 SUB: modulo 2^WIDTH, no overflow trap.
  - 02 AND, 03 OR, 04 XOR, 05 NOR.
  - 06 SLT (signed), 07 SLTU: result is 1 or 0, zero-extended.
  - 08 SLL, 09 SRL, 0A SRA: shift B by IdExShamt.
  - 0B LUI: B[15:0] followed by 16 zeros.
  - 0C MULT, 0D MULTU, 0E DIV, 0F DIVU.
  - 10 MFHI returns Hi; 11 MFLO returns Lo.
  - Any other code returns 0.
- Destination index = IdExRegDst ? IdExRd : IdExRt.
- ALU latency: 1 cycle. On a rising edge with ExBusy=0, EX/MEM captures the result, store data, destination and controls.
- If IdExValid=0, EX/MEM captures a bubble: ExMemWb, ExMemMemRead and ExMemMemWrite are 0.
- Mult/div ops always register ExMemWb=0 and no memory access.
- Mult/div FSM:
  - IDLE: a valid op 0C–0F at a clock edge latches the operands (magnitudes and sign flags for the signed ops) and enters BUSY with counter 0.
  - BUSY: ExBusy=1 (driven from the state register). One shift-add or restoring-subtract step per cycle.
  - After WIDTH cycles in BUSY: Hi/Lo are written, the FSM returns to IDLE, and ExBusy falls in the same cycle.
  - For the signed ops, result signs are corrected in the final step.
- Mult/div results:
  - MULT/MULTU: {Hi,Lo} = full 2*WIDTH-bit product.
  - DIV/DIVU: Lo = quotient, Hi = remainder; the remainder takes the dividend's sign.
  - Divide by zero: Lo = all ones, Hi = dividend. Not trapped.
  - Signed 0x80000000 / -1: Lo = 0x80000000, Hi = 0.
- While ExBusy=1:
  - EX/MEM holds its value.
  - New mult/div issue is impossible, because ID/EX is frozen.
  - The instruction held in EX re-evaluates each cycle with stable forwarding sources and commits on the first edge with ExBusy=0.
- MFHI/MFLO directly after a mult/div read the final Hi/Lo, because of the freeze.

Test Plan:
- ADD with FwdA=2, FwdB=1, ExMemAluOut=5, MemWbData=7 -> next cycle ExMemAluOut=12, ExMemWb=1, ExMemRd=IdExRd when RegDst=1.
- SW with AluSrc=1, Imm=4, rs=0x100, FwdB=2 -> ExMemAluOut=0x104, ExMemStoreData=previous ExMemAluOut, ExMemMemWrite=1.
- MULT 0xFFFFFFFE × 3 -> ExBusy high exactly 32 cycles, Hi=0xFFFFFFFF, Lo=0xFFFFFFFA; a following MFLO yields 0xFFFFFFFA.
- DIV -7 / 2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF. DIVU 9 / 0 -> Lo=0xFFFFFFFF, Hi=9.
- rst_n pulsed low at busy cycle 10 of a DIVU -> ExBusy=0, Hi=Lo=0, EX/MEM zero immediately; the next instruction executes normally.
- IdExValid=0 with RegWrite=1 and MemWrite=1 -> ExMemWb=0, ExMemMemWrite=0. SLT with -1 vs 1 -> 1; SLTU with the same operands -> 0.
